pwm_ramp_seq: RTL and testbench

//   Hardware duty-cycle ramp sequencer and register-bus arbiter between instr_dcd and regs.

---
 rtl/pwm_ramp_seq.sv | 200 ++++++++++++++++++++
 tb/tb_pwm_ramp_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_seq.sv
// Duty-cycle ramp sequencer: steps compare1 through the regs byte bus, yielding to instr_dcd.
// Optional macro PWM_RAMP_LOOP_EN turns the one-shot ramp into a continuous back-and-forth sweep.
module pwm_ramp_seq #(
  parameter logic [5:0] CMP1_ADDR_L = 6'h06
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dcd_read,
  input  logic        dcd_write,
  input  logic [5:0]  dcd_addr,
  input  logic [7:0]  dcd_data_write,
  output logic        reg_read,
  output logic        reg_write,
  output logic [5:0]  reg_addr,
  output logic [7:0]  reg_data_write,
  input  logic [15:0] count_val,
  input  logic        en,
  input  logic        seq_start,
  input  logic        seq_stop,
  input  logic [15:0] ramp_start,
  input  logic [15:0] ramp_end,
  input  logic [15:0] ramp_step,
  input  logic [7:0]  periods_per_step,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR_L = 2'd1;
  localparam logic [1:0] ST_WR_H = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] end_q, end_d;
  logic [15:0] step_q, step_d;
  logic [7:0]  pps_q, pps_d;
  logic [7:0]  wrap_cnt_q, wrap_cnt_d;
  logic        dir_q, dir_d;
  logic        stop_pend_q, stop_pend_d;
  logic        done_q, done_d;
  logic [15:0] count_val_q, count_val_d;
`ifdef PWM_RAMP_LOOP_EN
  logic [15:0] start_q, start_d;
`endif

  logic        dcd_busy;
  logic        seq_req;
  logic        grant;
  logic        tick;
  logic        stop_now;
  logic [5:0]  seq_addr;
  logic [7:0]  seq_data;
  logic [16:0] sum;
  logic [16:0] diff;
  logic [15:0] next_val;
  logic [8:0]  wrap_inc;

  assign dcd_busy = dcd_read | dcd_write;
  assign seq_req  = (state_q == ST_WR_L) || (state_q == ST_WR_H);
  assign grant    = seq_req & ~dcd_busy;
  assign tick     = en && (count_val == 16'd0) && (count_val_q != 16'd0);
  assign stop_now = stop_pend_q | seq_stop;
  assign wrap_inc = {1'b0, wrap_cnt_q} + 9'd1;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  // SPI owns the bus whenever it is active; the sequencer only drives it in the gaps.
  always_comb begin
    seq_addr       = (state_q == ST_WR_H) ? (CMP1_ADDR_L + 6'd1) : CMP1_ADDR_L;
    seq_data       = (state_q == ST_WR_H) ? cur_q[15:8] : cur_q[7:0];
    reg_read       = dcd_read;
    reg_write      = dcd_write;
    reg_addr       = dcd_addr;
    reg_data_write = dcd_data_write;
    if (!dcd_busy && seq_req) begin
      reg_read       = 1'b0;
      reg_write      = 1'b1;
      reg_addr       = seq_addr;
      reg_data_write = seq_data;
    end
  end

  // The 17th bit catches wrap past 0x0000/0xFFFF so the clamp also covers overflow.
  always_comb begin
    sum  = {1'b0, cur_q} + {1'b0, step_q};
    diff = {1'b0, cur_q} - {1'b0, step_q};
    if (dir_q) begin
      next_val = (sum[16] || (sum[15:0] > end_q)) ? end_q : sum[15:0];
    end else begin
      next_val = (diff[16] || (diff[15:0] < end_q)) ? end_q : diff[15:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    step_d      = step_q;
    pps_d       = pps_q;
    wrap_cnt_d  = wrap_cnt_q;
    dir_d       = dir_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    count_val_d = count_val;
`ifdef PWM_RAMP_LOOP_EN
    start_d     = start_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (seq_start && !seq_stop) begin
          cur_d       = ramp_start;
          end_d       = ramp_end;
          step_d      = (ramp_step == 16'd0) ? 16'd1 : ramp_step;
          pps_d       = (periods_per_step == 8'd0) ? 8'd1 : periods_per_step;
          dir_d       = (ramp_end >= ramp_start);
          wrap_cnt_d  = 8'd0;
          stop_pend_d = 1'b0;
`ifdef PWM_RAMP_LOOP_EN
          start_d     = ramp_start;
`endif
          state_d     = ST_WR_L;
        end
      end
      ST_WR_L: begin
        if (seq_stop) stop_pend_d = 1'b1;
        if (grant) state_d = ST_WR_H;
      end
      ST_WR_H: begin
        if (seq_stop) stop_pend_d = 1'b1;
        // An abort is only honoured here, once the MSB lands, so compare1 is never torn.
        if (grant) begin
          if (stop_now) begin
            stop_pend_d = 1'b0;
            state_d     = ST_IDLE;
          end else if (cur_q == end_q) begin
            done_d = 1'b1;
`ifdef PWM_RAMP_LOOP_EN
            start_d    = end_q;
            end_d      = start_q;
            dir_d      = ~dir_q;
            wrap_cnt_d = 8'd0;
            state_d    = ST_WAIT;
`else
            state_d    = ST_IDLE;
`endif
          end else begin
            wrap_cnt_d = 8'd0;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (seq_stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          wrap_cnt_d = wrap_inc[7:0];
          if (wrap_inc >= {1'b0, pps_q}) begin
            cur_d   = next_val;
            state_d = ST_WR_L;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= 16'd0;
      end_q       <= 16'd0;
      step_q      <= 16'd1;
      pps_q       <= 8'd1;
      wrap_cnt_q  <= 8'd0;
      dir_q       <= 1'b1;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      count_val_q <= 16'd0;
`ifdef PWM_RAMP_LOOP_EN
      start_q     <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      step_q      <= step_d;
      pps_q       <= pps_d;
      wrap_cnt_q  <= wrap_cnt_d;
      dir_q       <= dir_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      count_val_q <= count_val_d;
`ifdef PWM_RAMP_LOOP_EN
      start_q     <= start_d;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_ramp_seq.sv
// Bench for pwm_ramp_seq: directed and random ramps against a value-list model of the ramp.
// Covers the one-shot build by default and the sweep behaviour when PWM_RAMP_LOOP_EN is defined.
module tb_pwm_ramp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dcd_read, dcd_write;
  logic [5:0]  dcd_addr;
  logic [7:0]  dcd_data_write;
  logic        reg_read, reg_write;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_data_write;
  logic [15:0] count_val;
  logic        en, seq_start, seq_stop;
  logic [15:0] ramp_start, ramp_end, ramp_step;
  logic [7:0]  periods_per_step;
  logic        busy, done;

  int          errors = 0;
  int          checks = 0;
  int          cnt_period = 4;
  int          tick_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] prev_cnt = 16'd0;
  logic [13:0] got_q[$];
  int          exp_q[$];

  always #5 clk = ~clk;

  pwm_ramp_seq dut (
    .clk(clk), .rst_n(rst_n),
    .dcd_read(dcd_read), .dcd_write(dcd_write), .dcd_addr(dcd_addr), .dcd_data_write(dcd_data_write),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr), .reg_data_write(reg_data_write),
    .count_val(count_val), .en(en), .seq_start(seq_start), .seq_stop(seq_stop),
    .ramp_start(ramp_start), .ramp_end(ramp_end), .ramp_step(ramp_step),
    .periods_per_step(periods_per_step), .busy(busy), .done(done)
  );

  // Free-running counter model feeding count_val; freezes while en is low.
  initial begin
    count_val = 16'd0;
    forever begin
      @(posedge clk);
      #1;
      if (en) count_val = (int'(count_val) >= cnt_period - 1) ? 16'd0 : count_val + 16'd1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (en && count_val == 16'd0 && prev_cnt != 16'd0) tick_cnt++;
      prev_cnt = count_val;
    end
  end

  // Only sequencer-originated writes are logged; SPI cycles are checked separately.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && reg_write && !dcd_write && !dcd_read) got_q.push_back({reg_addr, reg_data_write});
      if (rst_n && done) done_cnt++;
    end
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] s, input logic [15:0] e,
                               input logic [15:0] st, input logic [7:0] p);
    ramp_start       = s;
    ramp_end         = e;
    ramp_step        = st;
    periods_per_step = p;
    seq_start        = 1'b1;
    stepClk();
    seq_start        = 1'b0;
  endtask

  task automatic buildRamp(input int s, input int e, input int st);
    int v;
    int stp;
    exp_q.delete();
    stp = (st == 0) ? 1 : st;
    v = s;
    exp_q.push_back(v);
    while (v != e) begin
      if (e >= s) v = (v + stp > e) ? e : v + stp;
      else        v = (v - stp < e) ? e : v - stp;
      exp_q.push_back(v);
    end
  endtask

`ifdef PWM_RAMP_LOOP_EN
  task automatic buildLoop(input int s, input int e, input int st, input int n);
    int a, b, v, stp, t;
    bit up;
    exp_q.delete();
    stp = (st == 0) ? 1 : st;
    a = s;
    b = e;
    up = (e >= s);
    v = s;
    exp_q.push_back(v);
    while (exp_q.size() < n) begin
      if (v == b) begin
        t = a;
        a = b;
        b = t;
        up = !up;
      end
      if (up) v = (v + stp > b) ? b : v + stp;
      else    v = (v - stp < b) ? b : v - stp;
      exp_q.push_back(v);
    end
  endtask
`endif

  task automatic waitIdle(input int max_cyc, input bit traffic);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      if (traffic && $urandom_range(0, 3) == 0) begin
        dcd_write      = 1'b1;
        dcd_addr       = 6'($urandom);
        dcd_data_write = 8'($urandom);
        @(negedge clk);
        checkOutput("bus_passthru", 32'({reg_write, reg_read, reg_addr, reg_data_write}),
                    32'({1'b1, 1'b0, dcd_addr, dcd_data_write}));
        stepClk();
        dcd_write = 1'b0;
      end else begin
        stepClk();
      end
      n++;
    end
    checkOutput("busy_after_ramp", 32'(busy), 32'd0);
    stepClk();
    stepClk();
  endtask

  task automatic checkRamp(input string tag, input int n_pairs);
    logic [15:0] ev;
    checkOutput({tag, "_len"}, 32'(got_q.size()), 32'(2 * n_pairs));
    for (int i = 0; i < n_pairs && 2 * i + 1 < got_q.size(); i++) begin
      ev = 16'(exp_q[i]);
      checkOutput($sformatf("%s_lsb%0d", tag, i), 32'(got_q[2*i]),   32'({6'h06, ev[7:0]}));
      checkOutput($sformatf("%s_msb%0d", tag, i), 32'(got_q[2*i+1]), 32'({6'h07, ev[15:8]}));
    end
  endtask

  task automatic runOneShot(input string tag, input logic [15:0] s, input logic [15:0] e,
                            input logic [15:0] st, input logic [7:0] p, input bit traffic);
    got_q.delete();
    done_cnt = 0;
    buildRamp(int'(s), int'(e), int'(st));
    applyStimulus(s, e, st, p);
    waitIdle(6000, traffic);
    checkRamp(tag, exp_q.size());
    checkOutput({tag, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int n;
    int t0;
    logic [15:0] rs, re, rst;
    logic [7:0]  rp;

    rst_n = 1'b0;
    dcd_read = 1'b0; dcd_write = 1'b0; dcd_addr = 6'd0; dcd_data_write = 8'd0;
    en = 1'b0; seq_start = 1'b0; seq_stop = 1'b0;
    ramp_start = 16'd0; ramp_end = 16'd0; ramp_step = 16'd0; periods_per_step = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_bus", 32'({reg_read, reg_write, reg_addr, reg_data_write}), 32'd0);
    stepClk();
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) stepClk();

`ifndef PWM_RAMP_LOOP_EN
    // Ramp up with latency check on the first pair.
    cnt_period = 4;
    got_q.delete();
    done_cnt = 0;
    buildRamp(0, 'h300, 'h100);
    applyStimulus(16'h0000, 16'h0300, 16'h0100, 8'd1);
    @(negedge clk);
    checkOutput("t1_first_lsb", 32'({reg_write, reg_addr, reg_data_write}), 32'({1'b1, 6'h06, 8'h00}));
    stepClk();
    @(negedge clk);
    checkOutput("t1_first_msb", 32'({reg_write, reg_addr, reg_data_write}), 32'({1'b1, 6'h07, 8'h00}));
    waitIdle(3000, 1'b0);
    checkRamp("t1", exp_q.size());
    checkOutput("t1_done", 32'(done_cnt), 32'd1);

    runOneShot("t2", 16'h0100, 16'h0000, 16'h0300, 8'd1, 1'b0);

    // SPI holds the bus for three cycles while the sequencer waits in WR_L.
    got_q.delete();
    done_cnt = 0;
    buildRamp('h5A3C, 'h5A3C, 1);
    applyStimulus(16'h5A3C, 16'h5A3C, 16'h0001, 8'd1);
    dcd_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dcd_addr       = 6'($urandom);
      dcd_data_write = 8'($urandom);
      @(negedge clk);
      checkOutput($sformatf("t3_spi%0d", i), 32'({reg_write, reg_read, reg_addr, reg_data_write}),
                  32'({1'b1, 1'b0, dcd_addr, dcd_data_write}));
      stepClk();
    end
    dcd_write = 1'b0;
    @(negedge clk);
    checkOutput("t3_seq_lsb", 32'({reg_write, reg_addr, reg_data_write}), 32'({1'b1, 6'h06, 8'h3C}));
    waitIdle(100, 1'b0);
    checkRamp("t3", exp_q.size());
    checkOutput("t3_done", 32'(done_cnt), 32'd1);

    // Abort during WR_L must still finish the MSB and suppress done.
    got_q.delete();
    done_cnt = 0;
    applyStimulus(16'h1234, 16'h5678, 16'h0100, 8'd1);
    seq_stop = 1'b1;
    @(negedge clk);
    checkOutput("t4_lsb", 32'({reg_write, reg_addr, reg_data_write}), 32'({1'b1, 6'h06, 8'h34}));
    stepClk();
    seq_stop = 1'b0;
    @(negedge clk);
    checkOutput("t4_msb", 32'({reg_write, reg_addr, reg_data_write}), 32'({1'b1, 6'h07, 8'h12}));
    checkOutput("t4_busy_msb", 32'(busy), 32'd1);
    stepClk();
    checkOutput("t4_busy_after", 32'(busy), 32'd0);
    repeat (3) stepClk();
    checkOutput("t4_done", 32'(done_cnt), 32'd0);
    checkOutput("t4_len", 32'(got_q.size()), 32'd2);

    // Dwell of three wraps per step with the counter paused after the first.
    cnt_period = 4;
    got_q.delete();
    done_cnt = 0;
    buildRamp(0, 'h200, 'h100);
    applyStimulus(16'h0000, 16'h0200, 16'h0100, 8'd3);
    n = 0;
    while (got_q.size() < 2 && n < 50) begin stepClk(); n++; end
    t0 = tick_cnt;
    n = 0;
    while (tick_cnt < t0 + 1 && n < 100) begin stepClk(); n++; end
    checkOutput("t5_first_wrap", 32'(n < 100), 32'd1);
    en = 1'b0;
    repeat (40) stepClk();
    checkOutput("t5_hold_len", 32'(got_q.size()), 32'd2);
    checkOutput("t5_hold_busy", 32'(busy), 32'd1);
    en = 1'b1;
    n = 0;
    while (tick_cnt < t0 + 3 && n < 100) begin stepClk(); n++; end
    checkOutput("t5_len_at_third", 32'(got_q.size()), 32'd2);
    @(negedge clk);
    checkOutput("t5_step_lsb", 32'({reg_write, reg_addr, reg_data_write}), 32'({1'b1, 6'h06, 8'h00}));
    waitIdle(3000, 1'b0);
    checkRamp("t5", exp_q.size());
    checkOutput("t5_done", 32'(done_cnt), 32'd1);

    // Start and stop together in IDLE: stop wins.
    got_q.delete();
    ramp_start = 16'h0040; ramp_end = 16'h0080;
    seq_start = 1'b1;
    seq_stop  = 1'b1;
    stepClk();
    seq_start = 1'b0;
    seq_stop  = 1'b0;
    checkOutput("t6_busy", 32'(busy), 32'd0);
    repeat (3) stepClk();
    checkOutput("t6_len", 32'(got_q.size()), 32'd0);

    runOneShot("t7_zero_step", 16'h0005, 16'h0008, 16'h0000, 8'd0, 1'b0);
    runOneShot("t8_ovf", 16'hFF00, 16'hFFFF, 16'h8000, 8'd1, 1'b0);

    // Random ramps with SPI traffic and a stray seq_start while busy.
    for (int k = 0; k < 6; k++) begin
      cnt_period = $urandom_range(2, 6);
      rs  = 16'($urandom);
      re  = 16'($urandom);
      rst = 16'($urandom_range(16'h0800, 16'h4000));
      rp  = 8'($urandom_range(0, 3));
      got_q.delete();
      done_cnt = 0;
      buildRamp(int'(rs), int'(re), int'(rst));
      applyStimulus(rs, re, rst, rp);
      repeat (3) stepClk();
      if (busy) begin
        ramp_start = ~rs;
        ramp_end   = ~re;
        seq_start  = 1'b1;
        stepClk();
        seq_start  = 1'b0;
      end
      waitIdle(6000, 1'b1);
      checkRamp($sformatf("rnd%0d", k), exp_q.size());
      checkOutput($sformatf("rnd%0d_done", k), 32'(done_cnt), 32'd1);
    end
`else
    // Continuous sweep between endpoints until stopped.
    cnt_period = 3;
    got_q.delete();
    done_cnt = 0;
    buildLoop('h10, 'h30, 'h10, 7);
    applyStimulus(16'h0010, 16'h0030, 16'h0010, 8'd1);
    n = 0;
    while (got_q.size() < 14 && n < 2000) begin stepClk(); n++; end
    checkRamp("loop", 7);
    checkOutput("loop_done", 32'(done_cnt), 32'd2);
    checkOutput("loop_busy", 32'(busy), 32'd1);
    seq_stop = 1'b1;
    stepClk();
    seq_stop = 1'b0;
    waitIdle(100, 1'b0);
`endif

    // Async reset mid-write drops to IDLE immediately.
    applyStimulus(16'h0100, 16'h0900, 16'h0100, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_bus", 32'({reg_write, reg_read}), 32'd0);
    stepClk();
    rst_n = 1'b1;
    stepClk();
    checkOutput("arst_busy_after", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
